// File: rtl/alu_mul_seq.sv
// Iterative radix-2 shift-add multiplier (LEGv8 MUL); ALU_MUL_HIGH_EN adds result_hi (UMULH upper half).
// Latency: operands accepted on edge t give out_valid from edge t+DATA_WIDTH+1, no early termination.
// Backpressure: result held in DONE while out_ready=0; in_ready is low outside IDLE.
module alu_mul_seq #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
`ifdef ALU_MUL_HIGH_EN
    ,
    output logic [DATA_WIDTH-1:0] result_hi
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
`ifdef ALU_MUL_HIGH_EN
    localparam int ACC_W = 2 * DATA_WIDTH;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    // Multiplicand is shifted one place per step, equivalent to mcand << count.
    logic [ACC_W-1:0]      r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0] r_result;
`ifdef ALU_MUL_HIGH_EN
    logic [DATA_WIDTH-1:0] r_result_hi;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
`ifdef ALU_MUL_HIGH_EN
            r_result_hi <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= ACC_W'(A);
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_count == CNT_LAST) begin
                        r_result    <= r_acc[DATA_WIDTH-1:0];
`ifdef ALU_MUL_HIGH_EN
                        r_result_hi <= r_acc[ACC_W-1:DATA_WIDTH];
`endif
                        r_state     <= S_DONE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
`ifdef ALU_MUL_HIGH_EN
    assign result_hi = r_result_hi;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: directed products, latency, backpressure, mid-op reset, random ops.
module tb_alu_mul_seq;

    localparam int DW = 64;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
`ifdef ALU_MUL_HIGH_EN
    logic [DW-1:0] result_hi;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_lo_q[$];
    logic [DW-1:0] exp_hi_q[$];

    alu_mul_seq #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef ALU_MUL_HIGH_EN
        ,
        .result_hi (result_hi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] elo, input logic [DW-1:0] ehi);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        A        = a;
        B        = b;
        exp_lo_q.push_back(elo);
        exp_hi_q.push_back(ehi);
        @(negedge clk);
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL in_ready_drop: got %b expected 0", in_ready);
        end
    endtask

    // Called right after issue(): counts negedges from acceptance until out_valid.
    task automatic await_result(input string name);
        int            n;
        logic [DW-1:0] elo;
        logic [DW-1:0] ehi;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        elo = exp_lo_q.pop_front();
        ehi = exp_hi_q.pop_front();
        vectors++;
        if (n != DW + 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, DW + 1);
        end
        vectors++;
        if (result !== elo) begin
            miscompares++;
            $display("FAIL %s result: got %h expected %h", name, result, elo);
        end
`ifdef ALU_MUL_HIGH_EN
        vectors++;
        if (result_hi !== ehi) begin
            miscompares++;
            $display("FAIL %s result_hi: got %h expected %h", name, result_hi, ehi);
        end
`endif
    endtask

    task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] elo, input logic [DW-1:0] ehi);
        out_ready = 1'b1;
        issue(a, b, elo, ehi);
        await_result(name);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s handshake_after: got in_ready=%b out_valid=%b expected 1 0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b result=%h expected 1 0 0",
                     in_ready, out_valid, result);
        end
`ifdef ALU_MUL_HIGH_EN
        vectors++;
        if (result_hi !== '0) begin
            miscompares++;
            $display("FAIL reset_result_hi: got %h expected 0", result_hi);
        end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op("basic", 64'd3, 64'd5, 64'd15, 64'd0);
        run_op("wrap", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd1);
        run_op("full_scale", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("zero", 64'd0, 64'h1234, 64'd0, 64'd0);
        run_op("one", 64'h0123_4567_89AB_CDEF, 64'd1, 64'h0123_4567_89AB_CDEF, 64'd0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(64'd123456789, 64'd1000, 64'd123456789000, 64'd0);
        await_result("bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                A        = 64'd7;
                B        = 64'd7;
            end
            if (i == 5) begin
                in_valid = 1'b0;
                A        = '0;
                B        = '0;
            end
            @(negedge clk);
            vectors++;
            if (result !== 64'd123456789000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got result=%h out_valid=%b in_ready=%b expected %h 1 0",
                         i, result, out_valid, in_ready, 64'd123456789000);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1 0",
                     in_ready, out_valid);
        end
        run_op("bp_next", 64'd7, 64'd7, 64'd49, 64'd0);
    endtask

    task automatic test_reset_mid_op();
        bit stale;
        stale     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = 64'd9;
        B         = 64'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL midreset_state: got in_ready=%b out_valid=%b result=%h expected 1 0 0",
                     in_ready, out_valid, result);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || result !== '0) stale = 1'b1;
        end
        vectors++;
        if (stale) begin
            miscompares++;
            $display("FAIL midreset_stale: got stale output expected none");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] p;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = (i % 2 == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 255));
            p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            run_op("random", a, b, p[DW-1:0], p[2*DW-1:DW]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
